addsub_pipe: RTL and testbench

Parametrised, carry-pipelined adder/subtractor for the DSP datapath, with a valid/ready handshake on both sides. Operands are split into CHUNK-bit slices, and one slice is resolved per pipeline stage, so wide words meet timing at the FPGA clock. It sits between operand registers and the accumulator/filter stages. It generalises the fixed 8-bit subtractor to any width, selects add or subtract per transaction, reports unsigned carry, signed overflow and zero flags, and optionally saturates.

---
 rtl/addsub_pipe_pkg.sv | 19 +
 rtl/addsub_chunk.sv | 21 ++
 rtl/addsub_pipe.sv | 126 ++++++++++++
 tb/tb_addsub_pipe.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pipe_pkg.sv
// rtl/addsub_pipe_pkg.sv - shared opcodes, stage-count helper and per-stage control payload
package addsub_pipe_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int stages(input int width, input int chunk);
        return (width / chunk < 1) ? 1 : width / chunk;
    endfunction

    // Control half of the stage payload; the module pairs it with WIDTH-sized skew/deskew vectors.
    typedef struct packed {
        logic valid;
        logic carry;
        logic ovf;
        logic sat;
    } stage_ctrl_t;

endpackage

// File: rtl/addsub_chunk.sv
// rtl/addsub_chunk.sv - combinational CHUNK-bit slice adder with carry into its MSB
module addsub_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] w_sum;

    assign w_sum    = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, cin};
    assign s        = w_sum[CHUNK-1:0];
    assign cout     = w_sum[CHUNK];
    // Carry into the top bit recovered from the sum bit, so it works for any CHUNK >= 1.
    assign c_msb_in = w_sum[CHUNK-1] ^ x[CHUNK-1] ^ y[CHUNK-1];

endmodule

// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - carry-pipelined add/sub, one CHUNK slice per stage; ADDSUB_PIPE_SAT_EN adds saturation
module addsub_pipe
    import addsub_pipe_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
`ifdef ADDSUB_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = stages(WIDTH, CHUNK);

    typedef struct packed {
        stage_ctrl_t      ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
    } stage_t;

    stage_t r_st  [STAGES];
    stage_t w_src [STAGES];
    stage_t w_nxt [STAGES];
    stage_t w_head;
    stage_t w_last;
    logic   w_en;
    logic   w_sat_in;

`ifdef ADDSUB_PIPE_SAT_EN
    assign w_sat_in = sat;
`else
    assign w_sat_in = 1'b0;
`endif

    // Subtract enters as a + ~b with carry-in 1 on slice 0.
    always_comb begin
        w_head            = '0;
        w_head.ctrl.valid = in_valid;
        w_head.ctrl.carry = (sub == OP_SUB);
        w_head.ctrl.sat   = w_sat_in;
        w_head.a          = a;
        w_head.b          = (sub == OP_SUB) ? ~b : b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_s;
        logic             w_cout;
        logic             w_c_msb;
        stage_t           w_n;

        if (k == 0) begin : g_first
            assign w_src[k] = w_head;
        end else begin : g_next
            assign w_src[k] = r_st[k-1];
        end

        addsub_chunk #(.CHUNK(CHUNK)) u_chunk (
            .x        (w_src[k].a[k*CHUNK +: CHUNK]),
            .y        (w_src[k].b[k*CHUNK +: CHUNK]),
            .cin      (w_src[k].ctrl.carry),
            .s        (w_s),
            .cout     (w_cout),
            .c_msb_in (w_c_msb)
        );

        // Only the last stage's ovf is meaningful; earlier stages overwrite it harmlessly.
        always_comb begin
            w_n                        = w_src[k];
            w_n.res[k*CHUNK +: CHUNK]  = w_s;
            w_n.ctrl.carry             = w_cout;
            w_n.ctrl.ovf               = w_cout ^ w_c_msb;
        end

        assign w_nxt[k] = w_n;
    end

`ifdef ADDSUB_PIPE_SAT_EN
    // On overflow both effective signs agree, so a's sign alone picks the clamp direction.
    always_comb begin
        w_last = w_nxt[STAGES-1];
        if (w_last.ctrl.sat && w_last.ctrl.ovf) begin
            w_last.res = w_src[STAGES-1].a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}};
        end
    end
`else
    assign w_last = w_nxt[STAGES-1];
`endif

    assign w_en = !r_st[STAGES-1].ctrl.valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_st[k] <= '0;
            end
        end else if (w_en) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_st[k] <= w_nxt[k];
            end
            r_st[STAGES-1] <= w_last;
        end
    end

    assign in_ready  = w_en;
    assign out_valid = r_st[STAGES-1].ctrl.valid;
    assign result    = r_st[STAGES-1].res;
    assign cout      = r_st[STAGES-1].ctrl.carry;
    assign ovf       = r_st[STAGES-1].ctrl.ovf;
    assign zero      = r_st[STAGES-1].ctrl.valid && (r_st[STAGES-1].res == '0);

endmodule

// File: tb/tb_addsub_pipe.sv
// tb/tb_addsub_pipe.sv - directed and randomized self-checking bench for addsub_pipe (16/8)
module tb_addsub_pipe;

    localparam int NR = 10000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        cout;
    logic        ovf;
    logic        zero;
`ifdef ADDSUB_PIPE_SAT_EN
    logic        sat;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [15:0] r;
        logic        c;
        logic        o;
        logic        z;
    } exp_t;

    exp_t q[$];

    logic [15:0] sa [6] = '{16'h0001, 16'h0010, 16'h0100, 16'hFFFF, 16'h4000, 16'h0005};
    logic [15:0] sb [6] = '{16'h0002, 16'h0020, 16'h0001, 16'h0001, 16'h4000, 16'h0007};
    logic        ss [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [15:0] sr [6] = '{16'h0003, 16'h0030, 16'h00FF, 16'h0000, 16'h8000, 16'hFFFE};
    logic        sc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        so [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic        sz [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    addsub_pipe #(.WIDTH(16), .CHUNK(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
`ifdef ADDSUB_PIPE_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [15:0] va, input logic [15:0] vb, input logic vs, input logic vsat);
        a   = va;
        b   = vb;
        sub = vs;
`ifdef ADDSUB_PIPE_SAT_EN
        sat = vsat;
`else
        if (vsat) $display("note: sat request ignored in wrapping build");
`endif
    endtask

    function automatic exp_t model(input logic [15:0] va, input logic [15:0] vb,
                                   input logic vs, input logic vsat);
        exp_t        e;
        logic [15:0] bw;
        logic [16:0] s;
        bw  = vs ? ~vb : vb;
        s   = {1'b0, va} + {1'b0, bw} + {16'd0, vs};
        e.r = s[15:0];
        e.c = s[16];
        e.o = (va[15] == bw[15]) && (s[15] != va[15]);
        if (vsat && e.o) e.r = va[15] ? 16'h8000 : 16'h7FFF;
        e.z = (e.r == 16'h0000);
        return e;
    endfunction

    // Called at posedge+1 with an empty pipe; leaves at posedge+1 with the pipe empty again.
    task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vs, input logic vsat, input logic [15:0] er,
                         input logic ec, input logic eo, input logic ez);
        int lat;
        drive(va, vb, vs, vsat);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, 2);
        check({tag, " result"}, result, er);
        check({tag, " cout"}, cout, ec);
        check({tag, " ovf"}, ovf, eo);
        check({tag, " zero"}, zero, ez);
        @(posedge clk); #1;
    endtask

    initial begin
        int   sent;
        int   recv;
        logic held;
        logic [15:0] h_res;
        logic h_c, h_o, h_z;
        exp_t e;
        logic rsat;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive(16'h0, 16'h0, 1'b0, 1'b0);
        #1;
        check("reset out_valid", out_valid, 0);
        check("reset in_ready", in_ready, 1);
        check("reset result", result, 0);
        check("reset cout", cout, 0);
        check("reset ovf", ovf, 0);
        check("reset zero", zero, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        do_op("sub_1234_0234", 16'h1234, 16'h0234, 1'b1, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0);
        do_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        do_op("sub_1234_1234", 16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        do_op("sub_0000_0001", 16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        do_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
        do_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
        do_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
`ifdef ADDSUB_PIPE_SAT_EN
        do_op("sat_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        do_op("sat_8000_0001", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 1'b0);
        do_op("sat_no_ovf", 16'h1234, 16'h0234, 1'b1, 1'b1, 16'h1000, 1'b1, 1'b0, 1'b0);
`endif

        // Six back-to-back ops with a 3-cycle downstream stall in the middle.
        sent = 0;
        recv = 0;
        held = 1'b0;
        for (int t = 0; t < 40 && recv < 6; t++) begin
            if (sent < 6) begin
                drive(sa[sent], sb[sent], ss[sent], 1'b0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            out_ready = !(t >= 3 && t < 6);
            #1;
            if (held) begin
                check("stall hold out_valid", out_valid, 1);
                check("stall hold result", result, h_res);
                check("stall hold cout", cout, h_c);
                check("stall hold ovf", ovf, h_o);
                check("stall hold zero", zero, h_z);
            end
            if (!out_ready) check("stall in_ready", in_ready, 0);
            held  = out_valid && !out_ready;
            h_res = result;
            h_c   = cout;
            h_o   = ovf;
            h_z   = zero;
            if (out_valid && out_ready) begin
                check($sformatf("stream[%0d] result", recv), result, sr[recv]);
                check($sformatf("stream[%0d] cout", recv), cout, sc[recv]);
                check($sformatf("stream[%0d] ovf", recv), ovf, so[recv]);
                check($sformatf("stream[%0d] zero", recv), zero, sz[recv]);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream received", recv, 6);
        check("stream sent", sent, 6);
        repeat (4) begin
            #1;
            check("stream no duplicate", out_valid, 0);
            @(posedge clk); #1;
        end

        // Reset with two ops in flight.
        drive(16'h1111, 16'h2222, 1'b0, 1'b0);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(16'h3333, 16'h0001, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("inflight out_valid", out_valid, 1);
        check("inflight result", result, 16'h3333);
        #2;
        rst = 1'b1;
        #1;
        check("async reset out_valid", out_valid, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (5) begin
            #1;
            check("post reset idle", out_valid, 0);
            @(posedge clk); #1;
        end
        do_op("post_reset_op", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);

        // Random traffic against the reference model.
        sent = 0;
        recv = 0;
        for (int cyc = 0; cyc < 60000 && recv < NR; cyc++) begin
`ifdef ADDSUB_PIPE_SAT_EN
            rsat = 1'($urandom_range(0, 1));
`else
            rsat = 1'b0;
`endif
            drive(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), rsat);
            in_valid  = (sent < NR) && ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                check("rand queue nonempty", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("rand result", result, e.r);
                    check("rand cout", cout, e.c);
                    check("rand ovf", ovf, e.o);
                    check("rand zero", zero, e.z);
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back(model(a, b, sub, rsat));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("rand received", recv, NR);
        check("rand pending", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
